pc_sequencer: RTL

//  Owns the architectural fetch PC register; drives the PC calculation datapath (selects and enables,

---
 rtl/pc_sequencer_pkg.sv | 32 +++
 rtl/pc_sequencer_calc.sv | 30 +++
 rtl/pc_sequencer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared encodings and defaults for the fetch PC sequencer and its datapath.
package pc_sequencer_pkg;

    localparam int unsigned DefaultXlen        = 32;
    localparam logic [31:0] DefaultResetVector = 32'h0000_0000;

    // Sequencer FSM state encoding
    localparam logic [1:0] StBoot  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StStall = 2'd2;
    localparam logic [1:0] StHalt  = 2'd3;

    // Next-PC source select
    localparam logic [1:0] SrcSeq    = 2'd0;
    localparam logic [1:0] SrcOffset = 2'd1;
    localparam logic [1:0] SrcPred   = 2'd2;
    localparam logic [1:0] SrcTarget = 2'd3;

    // Decode a source select into one-hot datapath enables {target, offset, prediction}
    function automatic logic [2:0] src_enables(input logic [1:0] src);
        logic [2:0] en;
        en = 3'b000;
        unique case (src)
            SrcTarget: en = 3'b100;
            SrcOffset: en = 3'b010;
            SrcPred:   en = 3'b001;
            default:   en = 3'b000;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/pc_sequencer_calc.sv
// PC calculation datapath: picks the next fetch address from the enabled source,
// defaulting to the sequential current + 4. Pure combinational, wraps modulo 2^XLEN.
module pc_sequencer_calc
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned XLEN = DefaultXlen
) (
    input  logic            offset_en,
    input  logic            target_en,
    input  logic            prediction_en,
    input  logic [XLEN-1:0] current,
    input  logic [XLEN-1:0] offset,
    input  logic [XLEN-1:0] target,
    input  logic [XLEN-1:0] prediction,
    output logic [XLEN-1:0] addr
);

    // Enables arrive one-hot; the priority order only matters if that is ever violated
    always_comb begin
        addr = current + XLEN'(4);
        if (target_en) begin
            addr = target;
        end else if (offset_en) begin
            addr = current + offset;
        end else if (prediction_en) begin
            addr = prediction;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: owns the architectural fetch PC, arbitrates redirect sources
// (execute > decode jump > predictor > sequential) and hands one PC per cycle to fetch.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned     XLEN         = DefaultXlen,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DefaultResetVector)
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic            halt_in,
    input  logic            fetch_ready_in,
    output logic            fetch_valid_out,
    output logic [XLEN-1:0] fetch_pc_out,
    output logic            fetch_pred_out,
    output logic            flush_out,
    output logic            misalign_out,
    input  logic            exe_redirect_in,
    input  logic [XLEN-1:0] exe_target_in,
    input  logic            dec_jump_in,
    input  logic [XLEN-1:0] dec_offset_in,
    input  logic            pred_taken_in,
    input  logic [XLEN-1:0] pred_target_in,
    output logic            calc_offset_en_out,
    output logic            calc_target_en_out,
    output logic            calc_prediction_en_out,
    output logic [XLEN-1:0] calc_current_out,
    output logic [XLEN-1:0] calc_offset_out,
    output logic [XLEN-1:0] calc_target_out,
    output logic [XLEN-1:0] calc_prediction_out
);

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q;
    logic            pred_q, flush_q, misalign_q;
    logic            valid, handshake, exe_take, update;
    logic [1:0]      src;
    logic [XLEN-1:0] calc_addr;

    assign valid     = (state_q == StRun) || (state_q == StStall);
    assign handshake = valid && fetch_ready_in;
    // Execute redirects are honoured in every state but BOOT, even with no handshake
    assign exe_take  = exe_redirect_in && (state_q != StBoot);
    assign update    = exe_take || handshake;

    // Fixed-priority source pick; losing requests are dropped, not buffered
    always_comb begin
        src = SrcSeq;
        if (exe_take) begin
            src = SrcTarget;
        end else if (handshake && dec_jump_in) begin
            src = SrcOffset;
        end else if (handshake && pred_taken_in) begin
            src = SrcPred;
        end
    end

    assign {calc_target_en_out, calc_offset_en_out, calc_prediction_en_out} = src_enables(src);

    assign calc_current_out    = pc_q;
    assign calc_offset_out     = dec_offset_in;
    assign calc_target_out     = exe_target_in;
    assign calc_prediction_out = pred_target_in;

    pc_sequencer_calc #(
        .XLEN(XLEN)
    ) u_calc (
        .offset_en     (calc_offset_en_out),
        .target_en     (calc_target_en_out),
        .prediction_en (calc_prediction_en_out),
        .current       (calc_current_out),
        .offset        (calc_offset_out),
        .target        (calc_target_out),
        .prediction    (calc_prediction_out),
        .addr          (calc_addr)
    );

    // Next-state logic; execute redirects never change state, only the PC
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StBoot: state_d = StRun;
            StRun, StStall: begin
                if (handshake) begin
                    state_d = halt_in ? StHalt : StRun;
                end else begin
                    state_d = StStall;
                end
            end
            StHalt: begin
                if (!halt_in) begin
                    state_d = StRun;
                end
            end
            default: state_d = StBoot;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= StBoot;
        end else begin
            state_q <= state_d;
        end
    end

    // PC and status flags; low address bits are always cleared on load
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pc_q       <= RESET_VECTOR;
            pred_q     <= 1'b0;
            flush_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            flush_q    <= exe_take;
            misalign_q <= update && (calc_addr[1:0] != 2'b00);
            if (update) begin
                pc_q   <= {calc_addr[XLEN-1:2], 2'b00};
                pred_q <= (src == SrcPred);
            end
        end
    end

    assign fetch_valid_out = valid;
    assign fetch_pc_out    = pc_q;
    assign fetch_pred_out  = pred_q;
    assign flush_out       = flush_q;
    assign misalign_out    = misalign_q;

endmodule
